floo_mcast_fork_ctrl: RTL
=========================

FLOO_MCAST_FORK_CTRL -- requirements
Module: floo_mcast_fork_ctrl

Interface
REQ-001 SHALL have parameter NumOutputs, default 5: number of fork output directions.
REQ-002 SHALL have parameter CntWidth, default 16: width of the stall counter.
REQ-003 SHALL have port clk_i, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port valid_i, input, 1: input flit valid.
REQ-006 SHALL have port ready_o, output, 1: input flit consumed this cycle.
REQ-007 SHALL have port mcast_i, input, 1: flit header multicast flag.
REQ-008 SHALL have port last_i, input, 1: flit is the last flit of its packet.
REQ-009 SHALL have port route_mask_i, input, NumOutputs: requested output directions for a head flit.
REQ-010 SHALL have port valid_o, output, NumOutputs: per-direction valid toward the output arbiters.
REQ-011 SHALL have port ready_i, input, NumOutputs: per-direction acceptance from the output arbiters.
REQ-012 SHALL have port done_mask_o, output, NumOutputs: directions that already accepted the current multicast flit.
REQ-013 SHALL have port busy_o, output, 1: FSM is in LOCKED.
REQ-014 SHALL have port err_o, output, 1: one-cycle pulse when an empty-mask flit is dropped.

Function
REQ-015 SHALL implement FSM states IDLE and LOCKED.
REQ-016 In IDLE, the active mask and mode SHALL be route_mask_i and mcast_i; in LOCKED, they SHALL be lock_mask_q and lock_mcast_q.
REQ-017 IDLE -> LOCKED SHALL occur on a completed input handshake (valid_i & ready_o) with last_i=0; lock_mask_q and lock_mcast_q SHALL capture route_mask_i and mcast_i.
REQ-018 LOCKED -> IDLE SHALL occur on a completed handshake with last_i=1; LOCKED SHALL otherwise persist, and route_mask_i SHALL be ignored.
REQ-019 Unicast mode: valid_o = valid_i & mask; ready_o = |(ready_i & valid_o).
REQ-020 Multicast mode: valid_o = valid_i & mask & ~done_q.
REQ-021 Multicast mode: ready_o = &((ready_i & valid_o) | ~mask | done_q).
REQ-022 done_q SHALL become done_q | (ready_i & valid_o) each cycle, and SHALL clear to 0 in the cycle ready_o=1, so the next flit starts clean.
REQ-023 done_mask_o SHALL equal done_q.
REQ-024 Each direction SHALL accept a multicast flit exactly once; no valid_o bit SHALL reassert for a direction already in done_q.
REQ-025 When all masked directions are ready in the same cycle, the flit SHALL complete in 1 cycle (zero added latency, combinational path).
REQ-026 If valid_i=1 and the active mask = 0: ready_o=1, valid_o=0, and err_o=1 for that cycle; the flit is dropped and the FSM follows REQ-017/018.
REQ-027 valid_o SHALL be 0 whenever valid_i=0.
REQ-028 done_q SHALL hold while valid_i deasserts mid-multicast (upstream is ready-first and holds valid).
REQ-029 ready_i asserted for an unmasked direction SHALL have no effect.

Reset
REQ-030 While rst_i=1 at a clock edge: FSM=IDLE, lock_mask_q=0, lock_mcast_q=0, done_q=0, and the stall counter=0.
REQ-031 Output values after reset: busy_o=0, done_mask_o=0, err_o=0; valid_o and ready_o follow REQ-019..021 combinationally.
REQ-032 Reset asserted mid-packet or mid-multicast SHALL abandon the partial state; the next flit SHALL be treated as a head flit.

Configuration
REQ-033 Macro FLOO_MCAST_FORK_STALL_CNT_EN defined: the block SHALL add output stall_cnt_o (CntWidth bits).
REQ-034 stall_cnt_o SHALL count the cycles with valid_i & ~ready_o, saturate at all-ones, and clear only on reset.
REQ-035 Macro FLOO_MCAST_FORK_STALL_CNT_EN not defined: port stall_cnt_o and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-036 Unicast test: mask=5'b00100, mcast=0, last=1, ready_i=5'b00100 -> valid_o=5'b00100, ready_o=1 in the same cycle, busy_o stays 0.
REQ-037 Staggered multicast test: mask=5'b01011, mcast=1, last=1; ready_i=5'b00001 in cycle 0, 5'b01000 in cycle 1, 5'b00010 in cycle 2.
- done_mask_o SHALL read 00001, then 01001.
- valid_o SHALL read 01011, then 01010, then 00010.
- ready_o=1 only in cycle 2; done_mask_o=0 in cycle 3.
REQ-038 Wormhole lock test: head flit with mask=5'b10000, last=0, accepted -> busy_o=1. Body flit with route_mask_i=5'b00001 -> routed to 10000. Tail with last=1 accepted -> busy_o=0 on the next cycle.
REQ-039 Empty-mask test: valid_i=1, mask=0 -> ready_o=1, valid_o=0, err_o=1 for exactly 1 cycle.
REQ-040 Reset mid-multicast test: done_q=5'b00011 and busy_o=1, then rst_i pulsed 1 cycle -> done_mask_o=0, busy_o=0; the next flit uses route_mask_i.
REQ-041 Stall counter test (macro defined, CntWidth=2): hold valid_i=1, ready_i=0 for 5 cycles -> stall_cnt_o sequence 1,2,3,3,3.

Source files
------------

// File: rtl/floo_mcast_fork_ctrl.sv
// floo_mcast_fork_ctrl: wormhole fork control; unicast or multicast with exactly-once delivery per direction.
// Define FLOO_MCAST_FORK_STALL_CNT_EN to add the saturating stall counter output stall_cnt_o.
module floo_mcast_fork_ctrl #(
    parameter int unsigned NumOutputs = 5,
    parameter int unsigned CntWidth   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  mcast_i,
    input  logic                  last_i,
    input  logic [NumOutputs-1:0] route_mask_i,
    output logic [NumOutputs-1:0] valid_o,
    input  logic [NumOutputs-1:0] ready_i,
    output logic [NumOutputs-1:0] done_mask_o,
    output logic                  busy_o,
    output logic                  err_o
`ifdef FLOO_MCAST_FORK_STALL_CNT_EN
    ,
    output logic [CntWidth-1:0]   stall_cnt_o
`endif
);
    typedef enum logic {IDLE, LOCKED} state_e;
    state_e                state_q, state_d;
    logic [NumOutputs-1:0] lock_mask_q, lock_mask_d, done_q, done_d, mask, acc;
    logic                  lock_mcast_q, lock_mcast_d, mcast, empty, hs;

    always_comb begin
        mask         = (state_q == LOCKED) ? lock_mask_q : route_mask_i;
        mcast        = (state_q == LOCKED) ? lock_mcast_q : mcast_i;
        empty        = ~|mask;
        valid_o      = {NumOutputs{valid_i}} & mask & ~(mcast ? done_q : '0);
        acc          = ready_i & valid_o;
        // an empty-mask flit is consumed and dropped so it cannot block the port
        ready_o      = (valid_i & empty) | (mcast ? &(acc | ~mask | done_q) : |acc);
        err_o        = valid_i & empty;
        hs           = valid_i & ready_o;
        done_d       = ready_o ? '0 : done_q | acc;
        state_d      = state_q;
        lock_mask_d  = lock_mask_q;
        lock_mcast_d = lock_mcast_q;
        if (hs && state_q == IDLE && !last_i) begin
            state_d      = LOCKED;
            lock_mask_d  = route_mask_i;
            lock_mcast_d = mcast_i;
        end else if (hs && state_q == LOCKED && last_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            lock_mask_q  <= '0;
            lock_mcast_q <= 1'b0;
            done_q       <= '0;
        end else begin
            state_q      <= state_d;
            lock_mask_q  <= lock_mask_d;
            lock_mcast_q <= lock_mcast_d;
            done_q       <= done_d;
        end
    end

    assign done_mask_o = done_q;
    assign busy_o      = (state_q == LOCKED);

`ifdef FLOO_MCAST_FORK_STALL_CNT_EN
    logic [CntWidth-1:0] stall_q, stall_d;

    always_comb stall_d = (valid_i && !ready_o && !(&stall_q)) ? stall_q + 1'b1 : stall_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) stall_q <= '0;
        else       stall_q <= stall_d;
    end

    assign stall_cnt_o = stall_q;
`endif
endmodule
